intermed_wire_seq: RTL and testbench

INTERMED_WIRE_SEQ -- requirements
Module: intermed_wire_seq

---
 rtl/intermed_wire_seq.sv | 114 +++++++++++
 tb/tb_intermed_wire_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/intermed_wire_seq.sv
// intermed_wire_seq: sweeps in_vec 0..7 with a programmable dwell and captures the returned datapath outputs per vector
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin one sweep (accepted only in IDLE)
//   dwell             extra hold cycles per vector, sampled at each counter load
//   out_1_in/out_2_in returned datapath outputs
//   in_vec            datapath drive {in_3,in_2,in_1}
//   busy              high while vectors are being applied/sampled
//   done              one-cycle sweep-complete pulse
//   results           {out_2_in,out_1_in} captured for vector k at bits [2k+1:2k]
//   expected/mismatch/err_idx  optional self-check, present only with INTERMED_WIRE_SEQ_CHECK_EN
module intermed_wire_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               out_1_in,
  input  logic               out_2_in,
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
  input  logic [15:0]        expected,
  output logic               mismatch,
  output logic [2:0]         err_idx,
`endif
  output logic [2:0]         in_vec,
  output logic               busy,
  output logic               done,
  output logic [15:0]        results
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t             state_q;
  logic [2:0]         k_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [15:0]        results_q;
  logic [2:0]         in_vec_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         pair_d;
  logic [2:0]         k_d;
  assign pair_d = {out_2_in, out_1_in};
  assign k_d = k_q + 3'd1;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
  logic       mismatch_q;
  logic [2:0] err_idx_q;
  logic       diff_d;
  assign diff_d = pair_d != expected[{k_q, 1'b0} +: 2];
  assign mismatch = mismatch_q;
  assign err_idx = err_idx_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      results_q <= '0;
      in_vec_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
      mismatch_q <= 1'b0;
      err_idx_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= APPLY;
          k_q       <= '0;
          cnt_q     <= dwell;
          results_q <= '0;
          in_vec_q  <= '0;
          busy_q    <= 1'b1;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
          mismatch_q <= 1'b0;
          err_idx_q  <= '0;
`endif
        end
        // counter reaching zero is the last APPLY cycle, so APPLY spans dwell+1 cycles
        APPLY: if (cnt_q == '0) state_q <= SAMPLE; else cnt_q <= cnt_q - DWELL_W'(1);
        SAMPLE: begin
          results_q[{k_q, 1'b0} +: 2] <= pair_d;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
          if (diff_d) begin
            mismatch_q <= 1'b1;
            if (!mismatch_q) err_idx_q <= k_q;
          end
`endif
          // exiting at k==7 keeps the index from ever wrapping
          if (k_q == 3'd7) begin
            state_q  <= DONE;
            in_vec_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            state_q  <= APPLY;
            k_q      <= k_d;
            in_vec_q <= k_d;
            cnt_q    <= dwell;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_vec = in_vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign results = results_q;
endmodule

// File: tb/tb_intermed_wire_seq.sv
// tb_intermed_wire_seq: directed checks of reset, sweep timing, start handling and captured results
module tb_intermed_wire_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  dwell;
  logic        out_1_in, out_2_in;
  logic [2:0]  in_vec;
  logic        busy, done;
  logic [15:0] results;
  int          n_cmp = 0, n_err = 0, done_cnt = 0;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
  logic [15:0] expected;
  logic        mismatch;
  logic [2:0]  err_idx;
  logic        exp_pre, exp_mm;
  logic [2:0]  exp_ei;
`endif
  always #5 clk = ~clk;
  assign out_1_in = in_vec[0] & in_vec[1];
  assign out_2_in = |in_vec;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  intermed_wire_seq #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dwell(dwell),
    .out_1_in(out_1_in), .out_2_in(out_2_in),
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
    .expected(expected), .mismatch(mismatch), .err_idx(err_idx),
`endif
    .in_vec(in_vec), .busy(busy), .done(done), .results(results)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic sweep(input int d, input int pk, input logic hold);
    dwell = d[3:0];
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < d + 2; j++) begin
        @(negedge clk);
        chk("vec", {11'd0, done, busy, in_vec}, {11'd0, 1'b0, 1'b1, k[2:0]});
        if (k == 0 && j == 0) chk("clr", results, 16'h0000);
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
        if (k == 7 && j == 0) chk("pre7", {15'd0, mismatch}, {15'd0, exp_pre});
`endif
        start = hold || (k == pk && j == 0);
      end
    @(negedge clk);
    chk("done", {11'd0, done, busy, in_vec}, 16'h0010);
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
    chk("mm", {12'd0, mismatch, err_idx}, {12'd0, exp_mm, exp_ei});
`endif
    start = hold;
    @(negedge clk);
    chk("idle", {11'd0, done, busy, in_vec}, 16'h0000);
    chk("res", results, 16'hEAE8);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    dwell = 4'd0;
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
    expected = 16'hEAE8;
    exp_pre = 1'b0;
    exp_mm = 1'b0;
    exp_ei = 3'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out", {11'd0, done, busy, in_vec}, 16'h0000);
    chk("rst_res", results, 16'h0000);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_vec", {11'd0, done, busy, in_vec}, 16'h000B);
    chk("mid_res", results, 16'h0028);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst1_out", {11'd0, done, busy, in_vec}, 16'h0000);
    chk("rst1_res", results, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_out", {11'd0, done, busy, in_vec}, 16'h0000);
    chk("abort_res", results, 16'h0000);
    chk("abort_done", done_cnt[15:0], 16'd0);
    sweep(0, -1, 1'b0);
    sweep(3, -1, 1'b0);
    sweep(0, 4, 1'b0);
    sweep(1, -1, 1'b1);
    sweep(2, -1, 1'b0);
    chk("done_cnt", done_cnt[15:0], 16'd5);
`ifdef INTERMED_WIRE_SEQ_CHECK_EN
    expected = 16'hEAEA;
    exp_pre = 1'b1;
    exp_mm = 1'b1;
    exp_ei = 3'd0;
    sweep(0, -1, 1'b0);
    expected = 16'h6AE8;
    exp_pre = 1'b0;
    exp_mm = 1'b1;
    exp_ei = 3'd7;
    sweep(0, -1, 1'b0);
    expected = 16'hEAE8;
    exp_mm = 1'b0;
    exp_ei = 3'd0;
    sweep(1, -1, 1'b0);
`endif
    repeat (3) @(negedge clk);
    chk("quiet", {11'd0, done, busy, in_vec}, 16'h0000);
    chk("hold_res", results, 16'hEAE8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
